// File: rtl/sb_dma_master_pkg.sv
// Shared bus constants and state encoding for the m1 word-copy DMA master.
package sb_dma_master_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTE_SEL_W     = 4;

  localparam logic [BYTE_SEL_W-1:0] SL_WORD = 4'b1111;
  localparam logic [BYTE_SEL_W-1:0] SL_NONE = 4'b0000;
  localparam logic                  SIGN_UNSIGNED = 1'b1;
  localparam logic [31:0]           ZERO32 = 32'h0000_0000;

  typedef enum logic [2:0] {
    DMA_IDLE    = 3'd0,
    DMA_RD_REQ  = 3'd1,
    DMA_RD_WAIT = 3'd2,
    DMA_WR_REQ  = 3'd3,
    DMA_DONE    = 3'd4
  } dma_state_t;

  function automatic logic [MEM_ADDR_WIDTH-1:0] word_align(input logic [MEM_ADDR_WIDTH-1:0] a);
    return {a[MEM_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sb_dma_master.sv
// Memory-to-memory word copy engine on the sb m1 master port; one beat in flight,
// all outputs come straight from flops so m1_gnt/m1_rdata never reach them combinationally.
module sb_dma_master
  import sb_dma_master_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [MEM_ADDR_WIDTH-1:0] src_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  input  logic                      m1_gnt,
  input  logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      m1_un_sign,
  output logic [BYTE_SEL_W-1:0]     m1_byte_mask,
  output logic                      m1_re,
  output logic                      m1_we,
  output logic [MEM_ADDR_WIDTH-1:0] m1_addr,
  output logic [DATA_WIDTH-1:0]     m1_wdata
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  dma_state_t                state_r, state_nxt_s;
  logic [MEM_ADDR_WIDTH-1:0] src_r, src_nxt_s, dst_r, dst_nxt_s, addr_s;
  logic [LEN_W-1:0]          rem_r, rem_nxt_s;
  logic [1:0]                lat_r, lat_nxt_s;
  logic [DATA_WIDTH-1:0]     buf_nxt_s;
  logic                      re_s, we_s, busy_s, done_s, aborted_s;
  logic [BYTE_SEL_W-1:0]     mask_s;

  assign m1_un_sign = SIGN_UNSIGNED;

  // Next-state and datapath update; m1_wdata doubles as the read-data buffer.
  always_comb begin
    state_nxt_s = state_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    rem_nxt_s   = rem_r;
    lat_nxt_s   = lat_r;
    buf_nxt_s   = m1_wdata;
    case (state_r)
      DMA_IDLE: begin
        if (start) begin
          src_nxt_s   = word_align(src_addr);
          dst_nxt_s   = word_align(dst_addr);
          rem_nxt_s   = len;
          state_nxt_s = (len == '0) ? DMA_DONE : DMA_RD_REQ;
        end else begin
          state_nxt_s = DMA_IDLE;
        end
      end
      DMA_RD_REQ: begin
        if (m1_gnt) begin
          if (RD_LAT == 0) begin
            buf_nxt_s   = m1_rdata;
            state_nxt_s = DMA_WR_REQ;
          end else begin
            lat_nxt_s   = LAT_LOAD;
            state_nxt_s = DMA_RD_WAIT;
          end
        end else begin
          state_nxt_s = DMA_RD_REQ;
        end
      end
      DMA_RD_WAIT: begin
        if (lat_r == 2'd0) begin
          buf_nxt_s   = m1_rdata;
          state_nxt_s = DMA_WR_REQ;
        end else begin
          lat_nxt_s   = lat_r - 2'd1;
        end
      end
      DMA_WR_REQ: begin
        if (m1_gnt) begin
          src_nxt_s   = src_r + 32'd4;
          dst_nxt_s   = dst_r + 32'd4;
          rem_nxt_s   = rem_r - LEN_W'(1);
          state_nxt_s = (rem_r == LEN_W'(1)) ? DMA_DONE : DMA_RD_REQ;
        end else begin
          state_nxt_s = DMA_WR_REQ;
        end
      end
      DMA_DONE: state_nxt_s = DMA_IDLE;
      default:  state_nxt_s = DMA_IDLE;
    endcase
    // Abort wins; a beat granted in this cycle is left uncounted.
    if (abort && (state_r != DMA_IDLE)) begin
      state_nxt_s = DMA_IDLE;
      src_nxt_s   = src_r;
      dst_nxt_s   = dst_r;
      rem_nxt_s   = rem_r;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Output values decoded from the next state so they can be registered.
  always_comb begin
    re_s      = (state_nxt_s == DMA_RD_REQ);
    we_s      = (state_nxt_s == DMA_WR_REQ);
    busy_s    = re_s | we_s | (state_nxt_s == DMA_RD_WAIT);
    done_s    = (state_nxt_s == DMA_DONE);
    aborted_s = abort && (state_r != DMA_IDLE);
    if (re_s) begin
      addr_s = src_nxt_s;
      mask_s = SL_WORD;
    end else if (we_s) begin
      addr_s = dst_nxt_s;
      mask_s = SL_WORD;
    end else begin
      addr_s = m1_addr;
      mask_s = SL_NONE;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= DMA_IDLE;
      src_r        <= ZERO32;
      dst_r        <= ZERO32;
      rem_r        <= '0;
      lat_r        <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      m1_re        <= 1'b0;
      m1_we        <= 1'b0;
      m1_addr      <= ZERO32;
      m1_wdata     <= ZERO32;
      m1_byte_mask <= SL_NONE;
    end else begin
      state_r      <= state_nxt_s;
      src_r        <= src_nxt_s;
      dst_r        <= dst_nxt_s;
      rem_r        <= rem_nxt_s;
      lat_r        <= lat_nxt_s;
      busy         <= busy_s;
      done         <= done_s;
      aborted      <= aborted_s;
      m1_re        <= re_s;
      m1_we        <= we_s;
      m1_addr      <= addr_s;
      m1_wdata     <= buf_nxt_s;
      m1_byte_mask <= mask_s;
    end
  end

endmodule
